// File: rtl/reduction_tree_if.sv
// Handshake bundle for reduction_tree: lane input beats in, group results out.
interface reduction_tree_if #(
  parameter int ACCUM_WIDTH = 32,
  parameter int NUM_LANES   = 4
);
  logic                              in_valid;
  logic                              in_ready;
  logic [NUM_LANES*ACCUM_WIDTH-1:0]  in_lsp;
  logic [NUM_LANES*ACCUM_WIDTH-1:0]  in_msp;
  logic                              sparse_en;
  logic                              in_last;
  logic                              out_valid;
  logic                              out_ready;
  logic [ACCUM_WIDTH-1:0]            out_data;
  logic                              out_sat;

  modport master (
    output in_valid, in_lsp, in_msp, sparse_en, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_lsp, in_msp, sparse_en, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/reduction_tree.sv
// Pipelined lane-combine + pairwise adder tree feeding a group accumulator.
// Define REDUCTION_SAT_EN for a signed saturating accumulator with sticky out_sat.
module reduction_tree #(
  parameter int ACCUM_WIDTH = 32,
  parameter int NUM_LANES   = 4
) (
  input  logic             clk,
  input  logic             rst,
  reduction_tree_if.slave  bus
);
  localparam int L = $clog2(NUM_LANES);
  localparam int W = ACCUM_WIDTH;

  logic         stall;
  logic         accept;
  logic [W-1:0] leaf_val [NUM_LANES];

  // Heap-indexed tree: node k sums children 2k and 2k+1; indices >= NUM_LANES are lanes.
  logic [W-1:0] node_d [1:NUM_LANES-1];
  logic [W-1:0] node_q [1:NUM_LANES-1];

  logic [L-1:0] vld_d, vld_q;
  logic [L-1:0] last_d, last_q;
  logic [L:0]   vld_shift, last_shift;

  logic [W-1:0] acc_d, acc_q;
  logic [W-1:0] out_data_d, out_data_q;
  logic         out_valid_d, out_valid_q;
  logic [W-1:0] acc_sum;
  logic         arrive;

  assign stall        = out_valid_q & ~bus.out_ready;
  assign accept       = bus.in_valid & ~stall;
  assign bus.in_ready = ~stall;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign leaf_val[gi] = bus.sparse_en
        ? bus.in_lsp[gi*W +: W] + bus.in_msp[gi*W +: W]
        : bus.in_lsp[gi*W +: W];
    end

    for (gi = 1; gi < NUM_LANES; gi++) begin : g_node
      if (2*gi >= NUM_LANES) begin : g_leaf_children
        assign node_d[gi] = leaf_val[2*gi-NUM_LANES] + leaf_val[2*gi+1-NUM_LANES];
      end else begin : g_node_children
        assign node_d[gi] = node_q[2*gi] + node_q[2*gi+1];
      end
    end
  endgenerate

  // Bit s of vld/last tags tree level s+1; bit L-1 accompanies the root sum.
  assign vld_shift  = {vld_q, accept};
  assign last_shift = {last_q, bus.in_last};
  assign vld_d      = vld_shift[L-1:0];
  assign last_d     = last_shift[L-1:0];
  assign arrive     = vld_q[L-1] & ~stall;

`ifdef REDUCTION_SAT_EN
  logic [W-1:0] add_raw;
  logic         ovf;
  logic         sat_d, sat_q;
  logic         out_sat_d, out_sat_q;

  always_comb begin
    add_raw = acc_q + node_q[1];
    ovf     = (acc_q[W-1] == node_q[1][W-1]) && (add_raw[W-1] != acc_q[W-1]);
    acc_sum = add_raw;
    if (ovf) begin
      acc_sum = acc_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

  always_comb begin
    sat_d     = sat_q;
    out_sat_d = out_sat_q;
    if (arrive) begin
      if (last_q[L-1]) begin
        out_sat_d = sat_q | ovf;
        sat_d     = 1'b0;
      end else begin
        sat_d     = sat_q | ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q     <= 1'b0;
      out_sat_q <= 1'b0;
    end else begin
      sat_q     <= sat_d;
      out_sat_q <= out_sat_d;
    end
  end

  assign bus.out_sat = out_sat_q;
`else
  assign acc_sum     = acc_q + node_q[1];
  assign bus.out_sat = 1'b0;
`endif

  // Without stall the pending result has been taken, so out_valid only survives
  // if a new last beat lands in the same cycle.
  always_comb begin
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (!stall) begin
      out_valid_d = 1'b0;
      if (arrive) begin
        if (last_q[L-1]) begin
          out_data_d  = acc_sum;
          out_valid_d = 1'b1;
          acc_d       = '0;
        end else begin
          acc_d       = acc_sum;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      for (int k = 1; k < NUM_LANES; k++) begin
        node_q[k] <= node_d[k];
      end
      last_q <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (!stall) begin
        vld_q <= vld_d;
      end
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_reduction_tree.sv
// Directed self-checking bench for reduction_tree (ACCUM_WIDTH=32, NUM_LANES=4).
module tb_reduction_tree;
  localparam int W = 32;
  localparam int N = 4;
  localparam int TIMEOUT = 20;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  reduction_tree_if #(.ACCUM_WIDTH(W), .NUM_LANES(N)) bus ();

  reduction_tree #(.ACCUM_WIDTH(W), .NUM_LANES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] lanes(input logic [W-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [N*W-1:0] all_lanes(input logic [W-1:0] v);
    return {v, v, v, v};
  endfunction

  task automatic drive(input logic [N*W-1:0] lsp, input logic [N*W-1:0] msp,
                       input logic sp, input logic lst);
    bus.in_valid  = 1'b1;
    bus.in_lsp    = lsp;
    bus.in_msp    = msp;
    bus.sparse_en = sp;
    bus.in_last   = lst;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.sparse_en = 1'b0;
    bus.in_lsp    = '0;
    bus.in_msp    = '0;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!bus.out_valid && cycles < TIMEOUT) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
    tests++; if (bus.out_data !== 32'd0) begin fails++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
    tests++; if (bus.out_sat !== 1'b0) begin fails++; $display("FAIL reset_out_sat got %0b want 0", bus.out_sat); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
    $display("[TB] reset done");
  endtask

  task automatic test_single(input string name, input logic [N*W-1:0] lsp,
                             input logic [N*W-1:0] msp, input logic sp,
                             input logic [W-1:0] exp_data);
    @(negedge clk);
    drive(lsp, msp, sp, 1'b1);
    @(negedge clk);
    idle();
    @(negedge clk);
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL %s_early got out_valid=%0b want 0", name, bus.out_valid); end
    @(negedge clk);
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL %s_latency got out_valid=%0b want 1", name, bus.out_valid); end
    tests++; if (bus.out_data !== exp_data) begin fails++; $display("FAIL %s_data got %h want %h", name, bus.out_data, exp_data); end
    tests++; if (bus.out_sat !== 1'b0) begin fails++; $display("FAIL %s_sat got %0b want 0", name, bus.out_sat); end
    $display("[TB] %s result %h", name, bus.out_data);
    @(negedge clk);
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL %s_drop got out_valid=%0b want 0", name, bus.out_valid); end
  endtask

  task automatic test_group();
    int n;
    logic [W-1:0] d;
    n = 0;
    d = '0;
    @(negedge clk); drive(all_lanes(32'd1), all_lanes(32'd9), 1'b0, 1'b0);
    @(negedge clk); drive(all_lanes(32'd2), all_lanes(32'd9), 1'b0, 1'b0);
    @(negedge clk); drive(all_lanes(32'd3), all_lanes(32'd9), 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idle();
      if (bus.out_valid && bus.out_ready) begin
        n++;
        d = bus.out_data;
      end
    end
    tests++; if (n != 1) begin fails++; $display("FAIL group_count got %0d want 1", n); end
    tests++; if (d !== 32'd24) begin fails++; $display("FAIL group_data got %h want %h", d, 32'd24); end
    $display("[TB] group results=%0d data=%h", n, d);
  endtask

  task automatic test_backpressure();
    int   cyc;
    logic stable;
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(all_lanes(32'd1), '0, 1'b0, 1'b1);
    @(negedge clk);
    drive(all_lanes(32'd2), '0, 1'b0, 1'b1);
    @(negedge clk);
    idle();
    wait_out(cyc);
    tests++; if (cyc >= TIMEOUT) begin fails++; $display("FAIL bp_timeout got %0d cycles want <%0d", cyc, TIMEOUT); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %0b want 0", bus.in_ready); end
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.out_data !== 32'd4 || bus.out_valid !== 1'b1) stable = 1'b0;
    end
    tests++; if (stable !== 1'b1) begin fails++; $display("FAIL bp_hold got data=%h valid=%0b want %h/1", bus.out_data, bus.out_valid, 32'd4); end
    $display("[TB] backpressure first result %h held", bus.out_data);
    bus.out_ready = 1'b1;
    @(negedge clk);
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_no_bubble got out_valid=%0b want 1", bus.out_valid); end
    tests++; if (bus.out_data !== 32'd8) begin fails++; $display("FAIL bp_second_data got %h want %h", bus.out_data, 32'd8); end
    $display("[TB] backpressure second result %h", bus.out_data);
    @(negedge clk);
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_no_dup got out_valid=%0b want 0", bus.out_valid); end
  endtask

  task automatic test_wrap();
    int cyc;
    logic [W-1:0] exp_d;
    logic         exp_s;
`ifdef REDUCTION_SAT_EN
    exp_d = 32'h7FFF_FFFF;
    exp_s = 1'b1;
`else
    exp_d = 32'hFFFF_FFFE;
    exp_s = 1'b0;
`endif
    @(negedge clk); drive(lanes(32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0), '0, 1'b0, 1'b0);
    @(negedge clk); drive(lanes(32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0), '0, 1'b0, 1'b1);
    @(negedge clk); idle();
    wait_out(cyc);
    tests++; if (cyc >= TIMEOUT) begin fails++; $display("FAIL wrap_timeout got %0d cycles want <%0d", cyc, TIMEOUT); end
    tests++; if (bus.out_data !== exp_d) begin fails++; $display("FAIL wrap_data got %h want %h", bus.out_data, exp_d); end
    tests++; if (bus.out_sat !== exp_s) begin fails++; $display("FAIL wrap_sat got %0b want %0b", bus.out_sat, exp_s); end
    $display("[TB] wrap result %h sat=%0b", bus.out_data, bus.out_sat);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_group();
    int n;
    logic [W-1:0] d;
    n = 0;
    d = '0;
    @(negedge clk); drive(all_lanes(32'd7), '0, 1'b0, 1'b0);
    @(negedge clk); drive(all_lanes(32'd7), '0, 1'b0, 1'b0);
    @(negedge clk); idle(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got %0b want 0", bus.out_valid); end
    drive(all_lanes(32'd5), '0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idle();
      if (bus.out_valid && bus.out_ready) begin
        n++;
        d = bus.out_data;
      end
    end
    tests++; if (n != 1) begin fails++; $display("FAIL midrst_count got %0d want 1", n); end
    tests++; if (d !== 32'd20) begin fails++; $display("FAIL midrst_data got %h want %h", d, 32'd20); end
    $display("[TB] reset mid-group result %h", d);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] got [$];
    logic         ready_ok;
    ready_ok = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b1) ready_ok = 1'b0;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
      drive(all_lanes(W'(i + 1)), all_lanes(32'd1), 1'b0, 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle();
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
    end
    tests++; if (ready_ok !== 1'b1) begin fails++; $display("FAIL b2b_in_ready got stalled want always 1"); end
    tests++; if (got.size() != 6) begin fails++; $display("FAIL b2b_count got %0d want 6", got.size()); end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      tests++;
      if (got[i] !== W'(4 * (i + 1))) begin
        fails++;
        $display("FAIL b2b_data[%0d] got %h want %h", i, got[i], W'(4 * (i + 1)));
      end
      $display("[TB] b2b result %0d = %h", i, got[i]);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    idle();
    test_reset();
    test_single("single", lanes(32'd1, 32'd2, 32'd3, 32'd4), all_lanes(32'd10), 1'b0, 32'd10);
    test_single("sparse", lanes(32'd1, 32'd2, 32'd3, 32'd4), all_lanes(32'd10), 1'b1, 32'd50);
    test_group();
    test_single("acc_cleared", all_lanes(32'd1), '0, 1'b0, 32'd4);
    test_backpressure();
    test_wrap();
    test_single("after_wrap", all_lanes(32'd1), '0, 1'b0, 32'd4);
    test_reset_mid_group();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
